// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types and constants for the single-precision operand front end
package fp_pkg;

    localparam int          EXP_W    = 8;
    localparam int          FRAC_W   = 23;
    localparam int          BIAS     = 127;
    localparam logic [7:0]  EXP_MAX  = 8'hFF;
    localparam int          QNAN_BIT = 22;
    localparam int          MANT_W   = FRAC_W + 1;

    typedef enum logic [2:0] {
        FP_ZERO   = 3'd0,
        FP_DENORM = 3'd1,
        FP_NORM   = 3'd2,
        FP_INF    = 3'd3,
        FP_QNAN   = 3'd4,
        FP_SNAN   = 3'd5
    } fp_class_e;

    // Round bits are appended by the consumer, so sig here is {hidden, frac}.
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] sig;
        fp_class_e         cls;
    } fp_unpacked_t;

endpackage

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - combinational decode of one packed binary32 word
module fp_classify
    import fp_pkg::*;
#(
    parameter bit FLUSH_DENORM = 1'b0
) (
    input  logic [31:0]  word,
    output fp_unpacked_t unp
);

    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;

    assign e = word[30:23];
    assign f = word[22:0];

    always_comb begin
        unp.sign = word[31];
        unp.exp  = e;
        unp.sig  = {1'b1, f};
        unp.cls  = FP_NORM;
        if (e == '0) begin
            if ((f == '0) || FLUSH_DENORM) begin
                unp.exp = '0;
                unp.sig = '0;
                unp.cls = FP_ZERO;
            end else begin
                // Denormals share the smallest normal exponent, without the hidden bit.
                unp.exp = 8'h01;
                unp.sig = {1'b0, f};
                unp.cls = FP_DENORM;
            end
        end else if (e == EXP_MAX) begin
            if (f == '0) begin
                unp.cls = FP_INF;
            end else if (f[QNAN_BIT]) begin
                unp.cls = FP_QNAN;
            end else begin
                unp.cls = FP_SNAN;
            end
        end
    end

endmodule

// File: rtl/fp_unpack.sv
// rtl/fp_unpack.sv - two-stage operand unpack pipeline with valid/ready and sticky invalid flag
module fp_unpack
    import fp_pkg::*;
#(
    parameter int GUARD_W      = 3,
    parameter bit FLUSH_DENORM = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          op_a,
    input  logic [31:0]          op_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 a_sign,
    output logic                 b_sign,
    output logic [EXP_W-1:0]     a_exp,
    output logic [EXP_W-1:0]     b_exp,
    output logic [23+GUARD_W:0]  a_sig,
    output logic [23+GUARD_W:0]  b_sig,
    output fp_class_e            a_class,
    output fp_class_e            b_class,
    output logic                 nan,
    output logic                 invalid,
    input  logic                 clr_flags,
    output logic                 invalid_sticky
);

    logic         s1_valid_q, s1_valid_d;
    logic [31:0]  s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic         s2_valid_q, s2_valid_d;
    fp_unpacked_t s2_a_q, s2_a_d, s2_b_q, s2_b_d;
    logic         sticky_q, sticky_d;
    fp_unpacked_t dec_a, dec_b;
    logic         s1_ready, s2_ready;

    fp_classify #(.FLUSH_DENORM(FLUSH_DENORM)) u_cls_a (.word(s1_a_q), .unp(dec_a));
    fp_classify #(.FLUSH_DENORM(FLUSH_DENORM)) u_cls_b (.word(s1_b_q), .unp(dec_b));

    assign s2_ready = !s2_valid_q || out_ready;
    assign s1_ready = !s1_valid_q || s2_ready;
    assign in_ready = s1_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s2_valid_d = s2_valid_q;
        s2_a_d     = s2_a_q;
        s2_b_d     = s2_b_q;
        sticky_d   = sticky_q;

        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_a_d = dec_a;
                s2_b_d = dec_b;
            end
        end

        if (s1_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d = op_a;
                s1_b_d = op_b;
            end
        end

        // Setting takes priority over a coincident clear.
        if (out_valid && out_ready && invalid) begin
            sticky_d = 1'b1;
        end else if (clr_flags) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_a_q     <= '0;
            s2_b_q     <= '0;
            sticky_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_valid_q <= s2_valid_d;
            s2_a_q     <= s2_a_d;
            s2_b_q     <= s2_b_d;
            sticky_q   <= sticky_d;
        end
    end

    assign out_valid      = s2_valid_q;
    assign a_sign         = s2_a_q.sign;
    assign b_sign         = s2_b_q.sign;
    assign a_exp          = s2_a_q.exp;
    assign b_exp          = s2_b_q.exp;
    assign a_sig          = {s2_a_q.sig, {GUARD_W{1'b0}}};
    assign b_sig          = {s2_b_q.sig, {GUARD_W{1'b0}}};
    assign a_class        = s2_a_q.cls;
    assign b_class        = s2_b_q.cls;
    assign nan            = (s2_a_q.cls == FP_QNAN) || (s2_a_q.cls == FP_SNAN) ||
                            (s2_b_q.cls == FP_QNAN) || (s2_b_q.cls == FP_SNAN);
    assign invalid        = (s2_a_q.cls == FP_SNAN) || (s2_b_q.cls == FP_SNAN);
    assign invalid_sticky = sticky_q;

endmodule

// File: tb/tb_fp_unpack.sv
// tb/tb_fp_unpack.sv - randomized scoreboard bench for fp_unpack
module tb_fp_unpack;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        a_sign, b_sign;
    logic [7:0]  a_exp, b_exp;
    logic [26:0] a_sig, b_sig;
    fp_class_e   a_class, b_class;
    logic        nan, invalid;
    logic        clr_flags = 1'b0;
    logic        invalid_sticky;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [38:0] a;
        logic [38:0] b;
        logic        nan;
        logic        inv;
    } exp_t;

    exp_t q[$];
    logic sticky_m = 1'b0;

    fp_unpack dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
        .a_sign(a_sign), .b_sign(b_sign), .a_exp(a_exp), .b_exp(b_exp),
        .a_sig(a_sig), .b_sig(b_sig), .a_class(a_class), .b_class(b_class),
        .nan(nan), .invalid(invalid), .clr_flags(clr_flags),
        .invalid_sticky(invalid_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, want);
        end
    endtask

    // Reference decode: {sign, exp, 27-bit sig, class code} from the binary32 rules.
    function automatic logic [38:0] ref_dec(input logic [31:0] w);
        int unsigned e, f, sig, cls, ex;
        e = (w >> 23) & 32'hFF;
        f = w & 32'h7FFFFF;
        if (e == 255) begin
            ex = 255; sig = (1 << 26) + f * 8;
            cls = (f == 0) ? 3 : ((f >= 32'h400000) ? 4 : 5);
        end else if (e == 0) begin
            if (f == 0) begin ex = 0; sig = 0; cls = 0; end
            else begin ex = 1; sig = f * 8; cls = 1; end
        end else begin
            ex = e; sig = (1 << 26) + f * 8; cls = 2;
        end
        return {w[31], 8'(ex), 27'(sig), 3'(cls)};
    endfunction

    function automatic logic [79:0] out_bus();
        return {2'b0, a_sign, a_exp, a_sig, 3'(a_class), b_sign, b_exp, b_sig, 3'(b_class), nan, invalid};
    endfunction

    // One clock: observe handshakes just before the edge, then sample after it.
    task automatic cycle(output logic acc, output logic del);
        exp_t e;
        #2;
        acc = in_valid && in_ready;
        del = out_valid && out_ready;
        if (del) begin
            if (q.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                e = q.pop_front();
                chk("op_a", 80'({a_sign, a_exp, a_sig, 3'(a_class)}), 80'(e.a));
                chk("op_b", 80'({b_sign, b_exp, b_sig, 3'(b_class)}), 80'(e.b));
                chk("nan_inv", 80'({nan, invalid}), 80'({e.nan, e.inv}));
                if (e.inv) sticky_m = 1'b1;
                else if (clr_flags) sticky_m = 1'b0;
            end
        end else if (clr_flags) begin
            sticky_m = 1'b0;
        end
        if (acc) begin
            e.a = ref_dec(op_a);
            e.b = ref_dec(op_b);
            e.nan = (e.a[2:0] >= 4) || (e.b[2:0] >= 4);
            e.inv = (e.a[2:0] == 5) || (e.b[2:0] == 5);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        chk("sticky", 80'(invalid_sticky), 80'(sticky_m));
    endtask

    task automatic drain();
        logic acc, del;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr_flags = 1'b0;
        for (int i = 0; i < 12 && q.size() != 0; i++) cycle(acc, del);
        chk("drain_empty", 80'(q.size()), 0);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        logic acc, del;
        in_valid = 1'b1; op_a = a; op_b = b; out_ready = 1'b1;
        cycle(acc, del);
        chk("send_acc", 80'(acc), 1);
        drain();
    endtask

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] f;
        case ($urandom_range(0, 4))
            0: e = 8'h00;
            1: e = 8'hFF;
            2: e = 8'h01;
            3: e = 8'hFE;
            default: e = 8'($urandom);
        endcase
        case ($urandom_range(0, 3))
            0: f = '0;
            1: f = 23'($urandom) | 23'h400000;
            2: f = (23'($urandom) & 23'h3FFFFF) | 23'h1;
            default: f = 23'($urandom);
        endcase
        return {1'($urandom), e, f};
    endfunction

    logic        acc, del;
    logic [79:0] snap;
    int          idx, accepted;
    logic [31:0] bp_ops[5];

    initial begin
        #12;
        chk("rst_out_valid", 80'(out_valid), 0);
        chk("rst_fields", out_bus(), 0);
        chk("rst_sticky", 80'(invalid_sticky), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_rst", 80'(in_ready), 1);

        // Latency: two edges from presentation to out_valid.
        in_valid = 1'b1; op_a = 32'h3F800000; op_b = 32'h00000001; out_ready = 1'b1;
        cycle(acc, del);
        in_valid = 1'b0;
        chk("lat_edge1", 80'(out_valid), 0);
        cycle(acc, del);
        chk("lat_edge2", 80'(out_valid), 1);
        chk("tp1_a", 80'({a_exp, a_sig, 3'(a_class)}), 80'({8'h7F, 27'h4000000, 3'd2}));
        chk("tp1_b", 80'({b_exp, b_sig, 3'(b_class)}), 80'({8'h01, 27'h0000008, 3'd1}));
        drain();

        send(32'h7F800001, 32'hFF800000);
        chk("snan_sticky", 80'(invalid_sticky), 1);
        send(32'h7FC00000, 32'h00000000);
        chk("qnan_sticky_kept", 80'(invalid_sticky), 1);

        // Clear coincident with an sNaN transfer: set wins.
        in_valid = 1'b1; op_a = 32'h7FA00000; op_b = 32'h3F800000; out_ready = 1'b1;
        cycle(acc, del);
        in_valid = 1'b0;
        for (int i = 0; i < 5 && !out_valid; i++) cycle(acc, del);
        clr_flags = 1'b1;
        cycle(acc, del);
        clr_flags = 1'b0;
        chk("clr_set_wins", 80'(invalid_sticky), 1);
        clr_flags = 1'b1;
        cycle(acc, del);
        clr_flags = 1'b0;
        chk("clr_alone", 80'(invalid_sticky), 0);
        drain();

        // Backpressure: five pairs against a 4-cycle stall.
        for (int i = 0; i < 5; i++) bp_ops[i] = rand_op();
        idx = 0; accepted = 0;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op_a = bp_ops[idx]; op_b = ~bp_ops[idx];
            snap = out_bus();
            cycle(acc, del);
            if (acc) begin idx++; accepted++; end
            if (i >= 2) chk("bp_stable", out_bus(), snap);
        end
        chk("bp_accepted", 80'(accepted), 2);
        chk("bp_in_ready_low", 80'(in_ready), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (idx < 5) begin in_valid = 1'b1; op_a = bp_ops[idx]; op_b = ~bp_ops[idx]; end
            else in_valid = 1'b0;
            chk("bp_tput", 80'(out_valid), 1);
            cycle(acc, del);
            if (acc) idx++;
        end
        chk("bp_all_in", 80'(idx), 5);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clr_flags = ($urandom_range(0, 7) == 0);
            op_a = rand_op();
            op_b = rand_op();
            cycle(acc, del);
        end
        drain();

        // Reset with both stages full and the sticky flag set.
        send(32'hFF800100, 32'h00000000);
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            op_a = rand_op(); op_b = rand_op();
            cycle(acc, del);
        end
        chk("pre_rst_full", 80'({out_valid, in_ready, invalid_sticky}), 80'(3'b101));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 80'(out_valid), 0);
        chk("mid_rst_sticky", 80'(invalid_sticky), 0);
        chk("mid_rst_fields", out_bus(), 0);
        q.delete();
        sticky_m  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 80'(in_ready), 1);
        chk("post_rst_valid", 80'(out_valid), 0);
        in_valid = 1'b1; op_a = 32'h80000000; op_b = 32'h00000000;
        cycle(acc, del);
        in_valid = 1'b0;
        cycle(acc, del);
        chk("neg_zero", 80'({out_valid, a_sign, a_exp, a_sig, 3'(a_class)}), 80'({1'b1, 1'b1, 8'h00, 27'h0, 3'd0}));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

endmodule
